dht11_scheduler: RTL



---
 rtl/dht11_scheduler.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dht11_scheduler.sv
// DHT11 measurement scheduler: periodic or forced triggering, response timeout,
// checksum validation with bounded retries, and publication of validated readings.
module dht11_scheduler #(
    parameter int unsigned SAMPLE_PERIOD  = 200_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 10_000_000,
    parameter int unsigned RETRY_GAP      = 100_000_000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        enable,
    input  logic        force_req,
    output logic        rd_start,
    input  logic        rd_done,
    input  logic        rd_error,
    input  logic [39:0] rd_data,
    output logic [7:0]  hum_int,
    output logic [7:0]  hum_float,
    output logic [7:0]  tmp_int,
    output logic [7:0]  tmp_float,
    output logic        valid,
    output logic        new_sample,
    output logic        fault,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);

    // Terminal timer values; the timer reads 0 in the first cycle of each state.
    localparam logic [31:0] PERIOD_LAST  = (SAMPLE_PERIOD  > 0) ? 32'(SAMPLE_PERIOD - 1)  : 32'd0;
    localparam logic [31:0] GAP_LAST     = (RETRY_GAP      > 0) ? 32'(RETRY_GAP - 1)      : 32'd0;
    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 1) ? 32'(TIMEOUT_CYCLES - 2) : 32'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RD,
        S_CHECK,
        S_FAIL,
        S_GAP,
        S_WAIT_PERIOD
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [31:0]         timer;
    logic [39:0]         frame;
    logic [RETRY_W-1:0]  retry;
    logic [7:0]          csum;
    logic                csum_ok;

    assign csum    = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    assign csum_ok = (csum == frame[7:0]);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
        end else begin
            // NOTE: state elements use non-blocking assignments so every register
            // samples the pre-edge values, independent of block ordering.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: the default keeps the current state on every path, so no latch is inferred.
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (enable) state_next = S_TRIG;
            end
            S_TRIG: begin
                state_next = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                // A protocol error outranks a simultaneous completion.
                if (rd_error)                   state_next = S_FAIL;
                else if (rd_done)               state_next = S_CHECK;
                else if (timer >= TIMEOUT_LAST) state_next = S_FAIL;
            end
            S_CHECK: begin
                if (!csum_ok)    state_next = S_FAIL;
                else if (enable) state_next = S_WAIT_PERIOD;
                else             state_next = S_IDLE;
            end
            S_FAIL: begin
                if (!enable)                  state_next = S_IDLE;
                else if (retry < RETRY_LIMIT) state_next = S_GAP;
                else                          state_next = S_WAIT_PERIOD;
            end
            S_GAP: begin
                if (!enable)                state_next = S_IDLE;
                else if (timer >= GAP_LAST) state_next = S_TRIG;
            end
            S_WAIT_PERIOD: begin
                if (!enable)                               state_next = S_IDLE;
                else if (force_req || timer >= PERIOD_LAST) state_next = S_TRIG;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            timer      <= '0;
            // NOTE: the capture register is reset as well, so the checksum never sees X.
            frame      <= '0;
            retry      <= '0;
            rd_start   <= 1'b0;
            busy       <= 1'b0;
            new_sample <= 1'b0;
            hum_int    <= '0;
            hum_float  <= '0;
            tmp_int    <= '0;
            tmp_float  <= '0;
            valid      <= 1'b0;
            fault      <= 1'b0;
            err_cnt    <= '0;
        end else begin
            timer      <= (state_next != state) ? 32'd0 : timer + 32'd1;
            rd_start   <= (state_next == S_TRIG);
            busy       <= state_next inside {S_TRIG, S_WAIT_RD, S_CHECK, S_FAIL};
            new_sample <= 1'b0;

            if (state == S_WAIT_RD && rd_done && !rd_error) begin
                frame <= rd_data;
            end

            if (state == S_CHECK && csum_ok) begin
                hum_int    <= frame[39:32];
                hum_float  <= frame[31:24];
                tmp_int    <= frame[23:16];
                tmp_float  <= frame[15:8];
                valid      <= 1'b1;
                new_sample <= 1'b1;
                fault      <= 1'b0;
                retry      <= '0;
            end

            if (state == S_FAIL) begin
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                if (retry < RETRY_LIMIT) begin
                    retry <= retry + RETRY_ONE;
                end else begin
                    fault <= 1'b1;
                    retry <= '0;
                end
            end

            // Leaving the schedule forgets any retry history.
            if (state_next == S_IDLE) begin
                retry <= '0;
            end
        end
    end

endmodule
